// File: rtl/fetch_sequencer_if.sv
// Bundle of fetch-sequencer signals: imem request/response, decode handoff, branch resolve, link write.
// Latency: none (wires only).
// Backpressure: carries imem_req/imem_ack and instr_valid/instr_ready; no storage here.
// Ports: master = sequencer side (drives imem_req/addr, instr*, flush, lr_*);
//        slave  = environment side (drives imem_ack/rdata, instr_ready, branch info).
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        br_valid;
    logic [10:0] ALUCtl_code;
    logic [23:0] br_address;
    logic [31:0] br_pc;
    logic        execute_flag;
    logic        flush;
    logic        lr_we;
    logic [31:0] lr_data;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, flush, lr_we, lr_data,
        input  imem_ack, imem_rdata, instr_ready, br_valid, ALUCtl_code, br_address, br_pc, execute_flag
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, flush, lr_we, lr_data,
        output imem_ack, imem_rdata, instr_ready, br_valid, ALUCtl_code, br_address, br_pc, execute_flag
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues imem requests, hands words to decode, applies B/BL redirects.
// Latency: ack->instr_valid 1 cycle, instr_ready->next imem_req 1 cycle, br_valid->flush/lr_we 1 cycle.
// Backpressure: holds one fetched word while instr_ready=0; no new request is issued until decode takes it.
// Ports: clk, reset (sync, active-high), bus (fetch_sequencer_if.master) carrying imem, decode, branch and r14 signals.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [10:0] ALUCTL_B  = 11'd31,
    parameter logic [10:0] ALUCTL_BL = 11'd32
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        flush_q, flush_d;
    logic        lr_we_q, lr_we_d;
    logic [31:0] lr_data_q, lr_data_d;

    logic        is_branch;
    logic        taken;
    logic        taken_bl;
    logic [31:0] target;

    assign is_branch = (bus.ALUCtl_code == ALUCTL_B) || (bus.ALUCtl_code == ALUCTL_BL);
    assign taken     = bus.br_valid & bus.execute_flag & is_branch;
    assign taken_bl  = bus.br_valid & bus.execute_flag & (bus.ALUCtl_code == ALUCTL_BL);
    // Word offset scaled to bytes; +8 accounts for the pipelined PC read-ahead. Wraps mod 2^32.
    assign target    = bus.br_pc + {{6{bus.br_address[23]}}, bus.br_address, 2'b00} + 32'd8;

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        flush_d     = taken;
        lr_we_d     = taken_bl;
        lr_data_d   = taken_bl ? (bus.br_pc + 32'd4) : lr_data_q;
        pc_d        = taken ? target : pc_q;

        case (state_q)
            BOOT: begin
                state_d     = FETCH;
                imem_addr_d = pc_d;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    if (kill_q || taken) begin
                        // Response belongs to a squashed path: drop it and refetch from the live pc.
                        kill_d      = 1'b0;
                        imem_addr_d = pc_d;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = imem_addr_q;
                        pc_d       = imem_addr_q + 32'd4;
                        state_d    = HOLD;
                    end
                end else if (taken) begin
                    // Request must stay stable until acked; remember to discard its data.
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (taken) begin
                    state_d     = FETCH;
                    imem_addr_d = pc_d;
                end else if (bus.instr_ready) begin
                    state_d     = FETCH;
                    imem_addr_d = pc_q;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            imem_addr_q <= RESET_PC;
            instr_q     <= 32'd0;
            instr_pc_q  <= 32'd0;
            flush_q     <= 1'b0;
            lr_we_q     <= 1'b0;
            lr_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            imem_addr_q <= imem_addr_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            flush_q     <= flush_d;
            lr_we_q     <= lr_we_d;
            lr_data_q   <= lr_data_d;
        end
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.flush       = flush_q;
    assign bus.lr_we       = lr_we_q;
    assign bus.lr_data     = lr_data_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory model with programmable wait, scoreboard of fetches/transfers.
// Latency: n/a.
// Backpressure: decode side is driven explicitly (instr_ready pulsed per accepted word).
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if ifc();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_wait = 0;
    int          wait_cnt = 0;
    int          last_ack = -1;
    bit          chk_gap  = 1'b0;
    logic [31:0] exp_f[$];
    logic [31:0] exp_x[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE1A0_5A00;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs settled: answer imem, score what the coming posedge will consume.
    task automatic step();
        logic [31:0] e;
        if (ifc.imem_req === 1'b1) begin
            if (wait_cnt >= mem_wait) begin
                ifc.imem_ack   = 1'b1;
                ifc.imem_rdata = mem_word(ifc.imem_addr);
                wait_cnt       = 0;
            end else begin
                ifc.imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            ifc.imem_ack = 1'b0;
            wait_cnt     = 0;
        end
        if (reset === 1'b0) begin
            if (ifc.imem_req === 1'b1 && ifc.imem_ack === 1'b1) begin
                check_val("fetch_expected", (exp_f.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_f.size() != 0) begin
                    e = exp_f.pop_front();
                    check_val("fetch_addr", ifc.imem_addr, e);
                end
                if (chk_gap && last_ack >= 0) check_val("fetch_gap", 32'(cyc - last_ack), 32'd2);
                last_ack = cyc;
            end
            if (ifc.instr_valid === 1'b1 && ifc.instr_ready === 1'b1) begin
                check_val("xfer_expected", (exp_x.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_x.size() != 0) begin
                    e = exp_x.pop_front();
                    check_val("instr_pc", ifc.instr_pc, e);
                    check_val("instr", ifc.instr, mem_word(e));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (ifc.instr_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_val(tag, 32'(ifc.instr_valid), 32'd1);
    endtask

    task automatic accept();
        ifc.instr_ready = 1'b1;
        step();
        ifc.instr_ready = 1'b0;
    endtask

    task automatic branch(input logic [10:0] code, input logic [31:0] bpc,
                          input logic [23:0] off, input logic ex);
        ifc.ALUCtl_code  = code;
        ifc.br_pc        = bpc;
        ifc.br_address   = off;
        ifc.execute_flag = ex;
        ifc.br_valid     = 1'b1;
        step();
        ifc.br_valid     = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        ifc.imem_ack     = 1'b0;
        ifc.imem_rdata   = 32'd0;
        ifc.instr_ready  = 1'b0;
        ifc.br_valid     = 1'b0;
        ifc.ALUCtl_code  = 11'd0;
        ifc.br_address   = 24'd0;
        ifc.br_pc        = 32'd0;
        ifc.execute_flag = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();

        check_val("rst_imem_req", 32'(ifc.imem_req), 32'd0);
        check_val("rst_imem_addr", ifc.imem_addr, 32'd0);
        check_val("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
        check_val("rst_instr", ifc.instr, 32'd0);
        check_val("rst_instr_pc", ifc.instr_pc, 32'd0);
        check_val("rst_flush", 32'(ifc.flush), 32'd0);
        check_val("rst_lr_we", 32'(ifc.lr_we), 32'd0);
        check_val("rst_lr_data", ifc.lr_data, 32'd0);

        reset = 1'b0;
        step();
        check_val("first_req", 32'(ifc.imem_req), 32'd1);
        check_val("first_addr", ifc.imem_addr, 32'd0);

        // Sequential fetch at peak rate.
        chk_gap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_f.push_back(32'(i * 4));
            exp_x.push_back(32'(i * 4));
            wait_valid("seq_valid");
            accept();
        end
        exp_f.push_back(32'hC);
        wait_valid("seq_valid_c");
        chk_gap = 1'b0;
        check_val("seq_flush", 32'(ifc.flush), 32'd0);
        check_val("seq_lr_we", 32'(ifc.lr_we), 32'd0);

        // Taken B while holding 0xC.
        branch(11'd31, 32'h100, 24'h000010, 1'b1);
        check_val("b_flush", 32'(ifc.flush), 32'd1);
        check_val("b_lr_we", 32'(ifc.lr_we), 32'd0);
        check_val("b_valid_drop", 32'(ifc.instr_valid), 32'd0);
        check_val("b_req", 32'(ifc.imem_req), 32'd1);
        check_val("b_target", ifc.imem_addr, 32'h148);
        exp_f.push_back(32'h148);
        exp_x.push_back(32'h148);
        step();
        check_val("b_flush_1cyc", 32'(ifc.flush), 32'd0);
        wait_valid("b_valid");
        accept();
        exp_f.push_back(32'h14C);
        wait_valid("b_valid_14c");

        // Target wraps past 2^32.
        branch(11'd31, 32'hFFFF_FFF8, 24'h000000, 1'b1);
        check_val("wrap_flush", 32'(ifc.flush), 32'd1);
        check_val("wrap_target", ifc.imem_addr, 32'h0);
        exp_f.push_back(32'h0);
        exp_x.push_back(32'h0);
        wait_valid("wrap_valid");
        accept();
        exp_f.push_back(32'h4);
        wait_valid("wrap_valid_4");

        // Taken BL with negative offset.
        branch(11'd32, 32'h200, 24'hFFFFFE, 1'b1);
        check_val("bl_flush", 32'(ifc.flush), 32'd1);
        check_val("bl_lr_we", 32'(ifc.lr_we), 32'd1);
        check_val("bl_lr_data", ifc.lr_data, 32'h204);
        check_val("bl_target", ifc.imem_addr, 32'h200);
        exp_f.push_back(32'h200);
        exp_x.push_back(32'h200);
        step();
        check_val("bl_lr_we_1cyc", 32'(ifc.lr_we), 32'd0);
        wait_valid("bl_valid");
        accept();
        exp_f.push_back(32'h204);
        wait_valid("bl_valid_204");

        // Untaken BL, and a taken non-branch code: no effect.
        branch(11'd32, 32'h300, 24'h000040, 1'b0);
        check_val("nt_flush", 32'(ifc.flush), 32'd0);
        check_val("nt_lr_we", 32'(ifc.lr_we), 32'd0);
        check_val("nt_valid", 32'(ifc.instr_valid), 32'd1);
        check_val("nt_instr_pc", ifc.instr_pc, 32'h204);
        branch(11'd5, 32'h300, 24'h000040, 1'b1);
        check_val("other_flush", 32'(ifc.flush), 32'd0);
        check_val("other_valid", 32'(ifc.instr_valid), 32'd1);
        exp_x.push_back(32'h204);
        accept();
        exp_f.push_back(32'h208);
        wait_valid("nt_valid_208");

        // Redirect to 0x8 under a 3-wait memory, then redirect again during the wait.
        mem_wait = 3;
        branch(11'd31, 32'h0, 24'h000000, 1'b1);
        check_val("w_addr", ifc.imem_addr, 32'h8);
        check_val("w_req", 32'(ifc.imem_req), 32'd1);
        exp_f.push_back(32'h8);
        exp_f.push_back(32'h148);
        step();
        branch(11'd31, 32'h100, 24'h000010, 1'b1);
        check_val("w_flush", 32'(ifc.flush), 32'd1);
        check_val("w_addr_held1", ifc.imem_addr, 32'h8);
        step();
        check_val("w_addr_held2", ifc.imem_addr, 32'h8);
        check_val("w_req_held", 32'(ifc.imem_req), 32'd1);
        step();
        check_val("w_killed_valid", 32'(ifc.instr_valid), 32'd0);
        check_val("w_next_addr", ifc.imem_addr, 32'h148);
        wait_valid("w_valid");
        check_val("w_hold_pc", ifc.instr_pc, 32'h148);
        check_val("w_hold_instr", ifc.instr, mem_word(32'h148));

        // Reset pulsed while holding.
        reset = 1'b1;
        step();
        check_val("mr_valid", 32'(ifc.instr_valid), 32'd0);
        check_val("mr_req", 32'(ifc.imem_req), 32'd0);
        check_val("mr_addr", ifc.imem_addr, 32'd0);
        reset    = 1'b0;
        mem_wait = 0;
        step();
        check_val("mr_first_req", 32'(ifc.imem_req), 32'd1);
        check_val("mr_first_addr", ifc.imem_addr, 32'd0);
        exp_f.push_back(32'h0);
        exp_x.push_back(32'h0);
        wait_valid("mr_valid_0");
        accept();

        check_val("fetch_q_drained", 32'(exp_f.size()), 32'd0);
        check_val("xfer_q_drained", 32'(exp_x.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter, sequences requests to instruction memory, hands fetched instructions to decode through a valid/ready handshake, and applies branch redirects (B/BL) resolved in execute. It sits between instruction memory and decode, and replaces a free-running PC+4 update with a stall- and flush-aware state machine. It also generates the r14 write for taken BL.

## Interface
- RESET_PC, 32'd0, first fetch address after reset
- ALUCTL_B, 11'd31, ALUCtl_code value for branch
- ALUCTL_BL, 11'd32, ALUCtl_code value for branch-with-link

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1 and not yet acked
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc valid for decode
- instr_ready  in  1  decode accepts
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- br_valid  in  1  one-cycle pulse: branch info below is valid
- ALUCtl_code  in  11  resolved instruction class
- br_address  in  24  signed word offset
- br_pc  in  32  address of the branch instruction
- execute_flag  in  1  condition passed
- flush  out  1  one-cycle pulse on taken redirect; downstream squashes younger work
- lr_we  out  1  one-cycle r14 write enable
- lr_data  out  32  r14 write value

## Operation
- All outputs are registered or decoded only from state registers; there is no combinational input-to-output path.
- States: BOOT, FETCH, HOLD. Internal registers: pc (next fetch address), kill (discard outstanding response).
- BOOT: imem_req=0. Transitions to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack with kill=0: instr<=imem_rdata, instr_pc<=imem_addr, pc<=imem_addr+4, go to HOLD.
  - On imem_ack with kill=1: data dropped, kill<=0, stay in FETCH; the next request uses the updated pc.
- HOLD: instr_valid=1, outputs frozen. On instr_ready, go to FETCH.
- Taken redirect: br_valid & execute_flag & (ALUCtl_code==ALUCTL_B or ALUCTL_BL).
  - target = br_pc + (sign-extend(br_address) << 2) + 8, computed modulo 2^32 (wraps).
  - Next cycle: flush=1 and pc<=target.
  - In HOLD: instr_valid drops and state goes to FETCH. If instr_ready is also high that cycle, the transfer counts, and decode squashes it via flush.
  - In FETCH without ack: the request continues unchanged until ack and kill<=1. With ack in the same cycle: data dropped, no kill.
  - A second redirect while kill=1 overwrites pc; last redirect wins.
- Taken BL: the cycle after br_valid, lr_we=1 and lr_data=br_pc+4. B or untaken branches: lr_we=0.
- Untaken branch, or br_valid with any other code: no flush, no pc change.

## Timing
- Reset values: state BOOT, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, flush=0, lr_we=0, lr_data=0.
- Reset mid-operation: next cycle everything takes its reset value; an outstanding request is abandoned, and imem must tolerate the dropped req.
- First imem_req: 2nd cycle after reset deasserts.
- Ack to instr_valid: 1 cycle. instr_ready to next imem_req: 1 cycle.
- Peak throughput with zero-wait memory and ready=1: one instruction per 2 cycles.
- br_valid to flush/lr_we: 1 cycle. br_valid to imem_req at target: 1 cycle if no request is outstanding, else 1 cycle after the pending ack.

## Test plan
- Reset, zero-wait memory, instr_ready=1 -> imem_addr 0x0,0x4,0x8 on alternate cycles; instr_pc matches each; flush=0, lr_we=0.
- B, br_pc=0x100, br_address=0x000010, execute_flag=1 -> flush one cycle, next fetch 0x148, lr_we=0. Same with br_pc=0xFFFFFFF8, br_address=0 -> fetch 0x00000000.
- BL, br_pc=0x200, br_address=0xFFFFFE -> fetch 0x200; lr_we=1 with lr_data=0x204 for exactly one cycle.
- ALUCtl_code=32 with execute_flag=0 -> no flush, no lr_we, fetch continues sequentially.
- Request 0x8 acked after 3 wait cycles, redirect to 0x148 during the wait -> imem_addr held at 0x8 until ack, no instr_valid for that data, next request 0x148.
- HOLD with instr_ready=0, reset pulsed -> next cycle instr_valid=0, imem_req=0; then a fetch at RESET_PC.
